// File: rtl/jt900h_pkg.sv
// Shared constants for the jt900h instruction fetch path.
package jt900h_pkg;

    localparam int unsigned AW         = 24;  // byte address width
    localparam int unsigned WORD_BYTES = 4;   // bytes per RAM fetch word
    localparam int unsigned USE_W      = 3;   // width of the decoder pop count

endpackage

// File: rtl/jt900h_prefetch_buf.sv
// Circular byte buffer: 4-byte masked write port, 4-byte read window, byte count.
module jt900h_prefetch_buf
    import jt900h_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic                      rst_n,
    input  logic                      clk,
    input  logic                      cen,
    input  logic                      flush,
    input  logic                      wr_en,
    input  logic [WORD_BYTES*8-1:0]   wr_data,
    input  logic [WORD_BYTES-1:0]     wr_mask,
    input  logic [USE_W-1:0]          rd_use,
    output logic [WORD_BYTES*8-1:0]   rd_data,
    output logic [CW-1:0]             cnt
);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] use_n;
    logic [CW-1:0] pop_n;
    logic [CW-1:0] push_n;

    // Write mask is contiguous from bit 0, so masked bytes pack at wr_ptr.
    always_comb begin
        use_n  = CW'(rd_use);
        pop_n  = (use_n > cnt) ? cnt : use_n;
        push_n = '0;
        for (int j = 0; j < WORD_BYTES; j++) begin
            push_n = push_n + CW'(wr_mask[j]);
        end
        if (!wr_en) push_n = '0;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            rd_data[8*i +: 8] = mem[rd_ptr + PW'(i)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (cen) begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
            end else begin
                rd_ptr <= rd_ptr + pop_n[PW-1:0];
                wr_ptr <= wr_ptr + push_n[PW-1:0];
                cnt    <= cnt - pop_n + push_n;
                for (int j = 0; j < WORD_BYTES; j++) begin
                    if (wr_en && wr_mask[j]) mem[wr_ptr + PW'(j)] <= wr_data[8*j +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/jt900h_prefetch.sv
// Instruction prefetch queue in front of jt900h_ramctl: fetch address, skip and align control.
// Define JT900H_QPC_EN to add the q_pc output (byte address of q_dout[7:0]).
module jt900h_prefetch
    import jt900h_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     rst_n,
    input  logic                     clk,
    input  logic                     cen,
    input  logic                     pc_load,
    input  logic [AW-1:0]            pc_new,
    output logic [AW-1:0]            req_addr,
    input  logic [31:0]              dout,
    input  logic                     ram_rdy,
    output logic [31:0]              q_dout,
    output logic [$clog2(DEPTH):0]   q_cnt,
`ifdef JT900H_QPC_EN
    output logic [AW-1:0]            q_pc,
`endif
    input  logic [USE_W-1:0]         q_use
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [AW-3:0] addr_q;
    logic          skip_q;
    logic [1:0]    align_q;
    logic          push;
    logic [31:0]   wr_data;
    logic [3:0]    wr_mask;

    assign req_addr = {addr_q, 2'b00};

    // Push is judged on the pre-pop count so a full word always fits.
    assign push    = ram_rdy && !skip_q && !pc_load && (q_cnt <= CW'(DEPTH - WORD_BYTES));
    assign wr_data = dout >> {align_q, 3'b000};
    assign wr_mask = 4'b1111 >> align_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            skip_q  <= 1'b0;
            align_q <= 2'd0;
        end else if (cen) begin
            if (pc_load) begin
                addr_q  <= pc_new[AW-1:2];
                align_q <= pc_new[1:0];
                // A word returning this very cycle is the stale one; nothing left to drop.
                skip_q  <= !ram_rdy;
            end else begin
                if (ram_rdy && skip_q) skip_q <= 1'b0;
                if (push) begin
                    addr_q  <= addr_q + 1'b1;
                    align_q <= 2'd0;
                end
            end
        end
    end

    jt900h_prefetch_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .rst_n   (rst_n),
        .clk     (clk),
        .cen     (cen),
        .flush   (pc_load),
        .wr_en   (push),
        .wr_data (wr_data),
        .wr_mask (wr_mask),
        .rd_use  (q_use),
        .rd_data (q_dout),
        .cnt     (q_cnt)
    );

`ifdef JT900H_QPC_EN
    logic [CW-1:0] pc_use_n;

    assign pc_use_n = (CW'(q_use) > q_cnt) ? q_cnt : CW'(q_use);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_pc <= '0;
        end else if (cen) begin
            if (pc_load) q_pc <= pc_new;
            else         q_pc <= q_pc + AW'(pc_use_n);
        end
    end
`endif

endmodule
